// File: rtl/pulse_pkg.sv
// ============================================================================
// Module   : pulse_pkg
// Purpose  : Shared state encoding and request-channel numbering for the
//            pulse sequencer and its helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_pkg;

  // Explicit-width state codes, kept as plain constants for legacy users
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STEP  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_STEP  = ST_STEP,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT
  } state_e;

  // Request/reply channel assignment
  localparam int CH_MEM_READ  = 0;
  localparam int CH_MEM_WRITE = 1;
  localparam int CH_OPERATE   = 2;

endpackage

`default_nettype wire

// File: rtl/pulse_wait_timer.sv
// ============================================================================
// Module   : pulse_wait_timer
// Purpose  : Counts cycles spent waiting for a reply and flags the cycle in
//            which the wait limit is reached. Only present in builds that
//            define PULSE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef PULSE_TIMEOUT_EN
module pulse_wait_timer #(
  parameter int LIMIT = 255,
  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] r_count;

  // Number of wait cycles already completed; restarts before each wait
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Counting the current cycle, the limit is reached on the LIMIT-th wait cycle
  assign expired = run && ((int'(r_count) + 1) >= LIMIT);

endmodule
`endif

`default_nettype wire

// File: rtl/pulse_sequencer.sv
// ============================================================================
// Module   : pulse_sequencer
// Purpose  : Walks a table of up to 2**STEP_W steps. Each step either lasts
//            one cycle or issues a one-cycle request on its channel and waits
//            for the matching reply. The table is captured at start so it may
//            change freely while the sequence runs.
// Options  : PULSE_TIMEOUT_EN - abort a wait after TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_sequencer
  import pulse_pkg::*;
#(
  parameter int STEP_W         = 3,
  parameter int REQ_CH         = 3,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int NUM_STEPS     = 2 ** STEP_W,
  localparam int CH_W          = (REQ_CH > 1) ? $clog2(REQ_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_pulse,
  input  logic [NUM_STEPS-1:0]      step_wait,
  input  logic [NUM_STEPS*CH_W-1:0] step_ch,
  input  logic [STEP_W-1:0]         last_step,
  output logic [REQ_CH-1:0]         req_pulse,
  input  logic [REQ_CH-1:0]         reply,
  output logic [STEP_W-1:0]         cur_step,
  output logic [NUM_STEPS-1:0]      entering_step,
  output logic                      busy,
  output logic                      done_pulse,
  output logic                      stray_reply,
  output logic                      timeout_pulse
);

  state_e                    r_state;
  logic [STEP_W-1:0]         r_cur;
  logic                      r_start_d;
  logic [REQ_CH-1:0]         r_reply_d;
  logic [NUM_STEPS-1:0]      r_wait;
  logic [NUM_STEPS*CH_W-1:0] r_ch;
  logic [STEP_W-1:0]         r_last;

  state_e                    w_state_nx;
  logic [STEP_W-1:0]         w_cur_nx;
  logic [STEP_W-1:0]         w_cur_inc;
  logic [CH_W-1:0]           w_sel_ch;
  logic [REQ_CH-1:0]         w_sel_mask;
  logic [REQ_CH-1:0]         w_wait_mask;
  logic                      w_sel_hit;
  logic                      w_is_last;
  logic                      w_expired;
  logic                      w_advance;
  logic                      w_enter;
  logic                      w_load;

  // Channel of the current step; an out-of-range code selects nothing
  assign w_sel_ch   = r_ch[int'(r_cur)*CH_W +: CH_W];
  assign w_sel_mask = REQ_CH'(1) << w_sel_ch;

  // Only the selected channel in WAIT counts as a real reply
  assign w_wait_mask = (r_state == S_WAIT) ? w_sel_mask : '0;
  assign w_sel_hit   = |(r_reply_d & w_wait_mask);
  assign w_is_last   = (r_cur == r_last);
  assign w_cur_inc   = r_cur + 1'b1;

`ifdef PULSE_TIMEOUT_EN
  // ISSUE always leads into WAIT, so it is the place to restart the count
  pulse_wait_timer #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (r_state == S_ISSUE),
    .run     (r_state == S_WAIT),
    .expired (w_expired)
  );

  // A selected reply in the limit cycle wins over the timeout
  assign timeout_pulse = (r_state == S_WAIT) && !w_sel_hit && w_expired;
`else
  logic unused_timeout_cfg;

  assign w_expired          = 1'b0;
  assign timeout_pulse      = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and next-step decision
  always_comb begin
    w_state_nx = r_state;
    w_cur_nx   = r_cur;
    w_load     = 1'b0;
    w_enter    = 1'b0;
    w_advance  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start_d) begin
          w_load     = 1'b1;
          w_enter    = 1'b1;
          w_cur_nx   = '0;
          w_state_nx = step_wait[0] ? S_ISSUE : S_STEP;
        end
      end
      S_STEP:  w_advance  = 1'b1;
      S_ISSUE: w_state_nx = S_WAIT;
      S_WAIT: begin
        if (w_sel_hit) begin
          w_advance = 1'b1;
        end else if (w_expired) begin
          w_state_nx = S_IDLE;
          w_cur_nx   = '0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_advance) begin
      if (w_is_last) begin
        w_state_nx = S_IDLE;
        w_cur_nx   = '0;
      end else begin
        w_enter    = 1'b1;
        w_cur_nx   = w_cur_inc;
        w_state_nx = r_wait[w_cur_inc] ? S_ISSUE : S_STEP;
      end
    end
  end

  // Input delay stage, state register and table capture at start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_start_d <= 1'b0;
      r_reply_d <= '0;
      r_wait    <= '0;
      r_ch      <= '0;
      r_last    <= '0;
    end else begin
      r_start_d <= start_pulse;
      r_reply_d <= reply;
      r_state   <= w_state_nx;
      r_cur     <= w_cur_nx;
      if (w_load) begin
        r_wait <= step_wait;
        r_ch   <= step_ch;
        r_last <= last_step;
      end
    end
  end

  assign cur_step      = r_cur;
  assign busy          = (r_state != S_IDLE);
  assign req_pulse     = (r_state == S_ISSUE) ? w_sel_mask : '0;
  assign done_pulse    = w_advance && w_is_last;
  assign stray_reply   = |(r_reply_d & ~w_wait_mask);
  assign entering_step = w_enter ? (NUM_STEPS'(1) << w_cur_nx) : '0;

endmodule

`default_nettype wire

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameter STEP_W, default 3, SHALL set the step-index width; NUM_STEPS = 2**STEP_W.
REQ-002 Parameter REQ_CH, default 3, SHALL set the request/reply channel count; CH_W = clog2(REQ_CH), minimum 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the wait limit; it is used only with PULSE_TIMEOUT_EN.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state on the rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start_pulse  in  1  sequence start request.
REQ-008 step_wait  in  NUM_STEPS  bit s=1: step s issues a request and waits for its reply.
REQ-009 step_ch  in  NUM_STEPS*CH_W  channel for step s, in slice [s*CH_W +: CH_W].
REQ-010 last_step  in  STEP_W  final step index of the sequence.
REQ-011 req_pulse  out  REQ_CH  one-cycle request per channel (0=mem read, 1=mem write, 2=operate).
REQ-012 reply  in  REQ_CH  per-channel completion pulses.
REQ-013 cur_step  out  STEP_W  current step index.
REQ-014 entering_step  out  NUM_STEPS  one-hot; high in the cycle before cur_step becomes k.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done_pulse  out  1  one cycle when the sequence completes normally.
REQ-017 stray_reply  out  1  one cycle when a reply arrives on an unselected channel, or outside WAIT.
REQ-018 timeout_pulse  out  1  one cycle when a wait is aborted.

Function
REQ-019 States SHALL be IDLE, STEP, ISSUE and WAIT.
REQ-020 start_pulse and reply SHALL be registered one cycle into start_d and reply_d; only the delayed copies SHALL drive the state machine.
REQ-021 IDLE with start_d=1 SHALL do the following on the same edge:
- latch step_wait, step_ch and last_step into shadow registers;
- set cur_step to 0 and go to STEP if shadow wait[0]=0, or to ISSUE if it is 1.
REQ-022 Input table changes during busy SHALL NOT affect the running sequence.
REQ-023 STEP SHALL last exactly one cycle, then advance.
REQ-024 ISSUE SHALL last one cycle with req_pulse[shadow ch[cur_step]]=1, then go to WAIT; at most one req_pulse bit SHALL be high in any cycle.
REQ-025 WAIT with reply_d[selected ch]=1 SHALL advance on that edge, so the minimum wait step is 2 cycles.
REQ-026 Advance when cur_step == shadow last_step SHALL set cur_step to 0, go to IDLE and assert done_pulse for one cycle.
REQ-027 Any other advance SHALL set cur_step to cur_step+1 and go to STEP or ISSUE according to shadow wait[cur_step+1].
REQ-028 entering_step SHALL be combinational from the next-state logic and SHALL be 0 when no step transition occurs.
REQ-029 start_d while busy SHALL be ignored (no queueing).
REQ-030 reply_d on a non-selected channel, or reply_d in any state except WAIT, SHALL pulse stray_reply and be otherwise ignored.
REQ-031 reply_d on both the selected and another channel in the same cycle SHALL advance and pulse stray_reply.
REQ-032 last_step = NUM_STEPS-1 SHALL complete normally; cur_step SHALL never wrap past last_step.

Reset
REQ-033 reset SHALL force, in the next cycle:
- state=IDLE, cur_step=0;
- start_d=0, reply_d=0, shadow registers=0, wait counter=0;
- all outputs 0.
REQ-034 Reset mid-sequence SHALL abort without done_pulse, and replies pending at reset SHALL be discarded.

Configuration
REQ-035 With PULSE_TIMEOUT_EN defined:
- a counter SHALL clear on entering WAIT and increment each WAIT cycle;
- when the count reaches TIMEOUT_CYCLES with no selected reply_d, the block SHALL pulse timeout_pulse, go to IDLE with cur_step=0, and give no done_pulse;
- a reply_d in the same cycle as the limit SHALL take priority (advance, no timeout).
REQ-036 Without PULSE_TIMEOUT_EN, no counter SHALL exist, timeout_pulse SHALL be tied 0, and WAIT SHALL be unbounded.

Structure
REQ-037 Package pulse_pkg SHALL hold:
- the state enum;
- channel constants CH_MEM_READ=0, CH_MEM_WRITE=1, CH_OPERATE=2.
REQ-038 Sub-module pulse_wait_timer SHALL hold the timeout counter, instantiated only under PULSE_TIMEOUT_EN.

Verification
REQ-039 Defaults, step_wait=8'b0000_0000, last_step=7, start_pulse at cycle 0 -> entering_step[0] at cycle 1, cur_step 0..7 on cycles 2..9, done_pulse at cycle 9, busy low from cycle 10.
REQ-040 step_wait=8'b0000_0010, step_ch[1]=0, last_step=2, reply[0] in the ISSUE cycle -> req_pulse=3'b001 for one cycle, step 1 lasts exactly 2 cycles, done_pulse after step 2.
REQ-041 Wait on ch 2, reply[1] then reply[2] -> stray_reply on reply[1], advance only after reply[2].
REQ-042 step_wait changed to all-ones mid-sequence and a second start_pulse while busy -> original sequence unchanged, no restart.
REQ-043 Reset asserted while in WAIT, then reply pulsed -> IDLE, all outputs 0, no done_pulse, no advance.
REQ-044 PULSE_TIMEOUT_EN with TIMEOUT_CYCLES=4, no reply -> timeout_pulse after 4 WAIT cycles, cur_step=0, no done_pulse; without the macro -> WAIT held for 1000 cycles.
